// File: rtl/baud_gen_pkg.sv
// Shared defaults and 50 MHz divisor constants for the fractional baud generator.
// Divisors are {integer clk cycles, sixteenths of a cycle} per sample tick.
package baud_gen_pkg;

    localparam int DEF_DIV_INT_WIDTH  = 16;
    localparam int DEF_DIV_FRAC_WIDTH = 4;
    localparam int DEF_OVERSAMPLE     = 16;

    typedef struct packed {
        logic [DEF_DIV_INT_WIDTH-1:0]  div_int;
        logic [DEF_DIV_FRAC_WIDTH-1:0] div_frac;
    } baud_div_t;

    localparam baud_div_t BAUD_9600_50M   = '{div_int: 16'd325, div_frac: 4'd8};
    localparam baud_div_t BAUD_19200_50M  = '{div_int: 16'd162, div_frac: 4'd12};
    localparam baud_div_t BAUD_115200_50M = '{div_int: 16'd27,  div_frac: 4'd2};
    localparam baud_div_t BAUD_256000_50M = '{div_int: 16'd12,  div_frac: 4'd3};

endpackage

// File: rtl/frac_accumulator.sv
// Fraction accumulator: adds the fractional divisor once per sample period and
// registers the carry-out that stretches the following period by one cycle.
module frac_accumulator
    import baud_gen_pkg::*;
#(
    parameter int FRAC_WIDTH = DEF_DIV_FRAC_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  step_i,
    input  logic [FRAC_WIDTH-1:0] frac_i,
    output logic                  carry_o
);

    logic [FRAC_WIDTH-1:0] r_acc;
    logic                  r_carry;
    logic [FRAC_WIDTH:0]   w_sum;

    assign w_sum   = {1'b0, r_acc} + {1'b0, frac_i};
    assign carry_o = r_carry;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            r_acc   <= '0;
            r_carry <= 1'b0;
        end else if (step_i) begin
            r_acc   <= w_sum[FRAC_WIDTH-1:0];
            r_carry <= w_sum[FRAC_WIDTH];
        end
    end

endmodule

// File: rtl/frac_baud_generator.sv
// Fractional-N baud generator producing oversample and bit tick pulses.
// Define BAUD_GEN_FRAC_DIV_EN to compile in the fractional accumulator.
module frac_baud_generator
    import baud_gen_pkg::*;
#(
    parameter int DIV_INT_WIDTH  = DEF_DIV_INT_WIDTH,
    parameter int DIV_FRAC_WIDTH = DEF_DIV_FRAC_WIDTH,
    parameter int OVERSAMPLE     = DEF_OVERSAMPLE
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      enable_i,
    input  logic                      restart_i,
    input  logic [DIV_INT_WIDTH-1:0]  div_int_i,
    input  logic [DIV_FRAC_WIDTH-1:0] div_frac_i,
    output logic                      sample_en_o,
    output logic                      bit_en_o,
    output logic                      cfg_err_o
);

    localparam int OS_W = $clog2(OVERSAMPLE);

    logic [DIV_INT_WIDTH-1:0] r_div_int;
    logic [DIV_INT_WIDTH-1:0] r_cnt;
    logic [OS_W-1:0]          r_os_cnt;
    logic                     r_sample_en;
    logic                     r_bit_en;

    logic w_cfg_err;
    logic w_run;
    logic w_restart;
    logic w_div_changed;
    logic w_carry;
    logic w_terminal;
    logic w_clear;
    logic w_step;

    assign w_cfg_err = (div_int_i < DIV_INT_WIDTH'(2));
    assign w_run     = enable_i & ~w_cfg_err;

`ifdef BAUD_GEN_FRAC_DIV_EN
    logic [DIV_FRAC_WIDTH-1:0] r_div_frac;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_div_frac <= '0;
        end else begin
            r_div_frac <= div_frac_i;
        end
    end

    assign w_div_changed = ({div_int_i, div_frac_i} != {r_div_int, r_div_frac});

    frac_accumulator #(
        .FRAC_WIDTH (DIV_FRAC_WIDTH)
    ) u_frac_accumulator (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (w_clear),
        .step_i  (w_step),
        .frac_i  (div_frac_i),
        .carry_o (w_carry)
    );
`else
    // Integer-only build: the fraction input has no effect on timing or restarts.
    logic w_unused_frac;
    assign w_unused_frac = ^div_frac_i;
    assign w_div_changed = (div_int_i != r_div_int);
    assign w_carry       = 1'b0;
`endif

    assign w_restart  = restart_i | w_div_changed;
    assign w_terminal = (r_cnt == (div_int_i - DIV_INT_WIDTH'(1) + DIV_INT_WIDTH'(w_carry)));
    assign w_clear    = ~w_run | w_restart;
    assign w_step     = ~w_clear & w_terminal;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_div_int   <= '0;
            r_cnt       <= '0;
            r_os_cnt    <= '0;
            r_sample_en <= 1'b0;
            r_bit_en    <= 1'b0;
        end else begin
            r_div_int <= div_int_i;
            if (w_clear) begin
                // Restart beats a coinciding terminal count: no tick this cycle.
                r_cnt       <= '0;
                r_os_cnt    <= '0;
                r_sample_en <= 1'b0;
                r_bit_en    <= 1'b0;
            end else if (w_terminal) begin
                r_cnt       <= '0;
                r_sample_en <= 1'b1;
                if (r_os_cnt == OS_W'(OVERSAMPLE - 1)) begin
                    r_os_cnt <= '0;
                    r_bit_en <= 1'b1;
                end else begin
                    r_os_cnt <= r_os_cnt + OS_W'(1);
                    r_bit_en <= 1'b0;
                end
            end else begin
                r_cnt       <= r_cnt + DIV_INT_WIDTH'(1);
                r_sample_en <= 1'b0;
                r_bit_en    <= 1'b0;
            end
        end
    end

    assign sample_en_o = r_sample_en;
    assign bit_en_o    = r_bit_en;
    assign cfg_err_o   = w_cfg_err;

endmodule

// File: tb/tb_frac_baud_generator.sv
// Directed self-checking bench for frac_baud_generator; fraction checks depend
// on whether BAUD_GEN_FRAC_DIV_EN is defined for the build.
module tb_frac_baud_generator;

    localparam int IW = 16;
    localparam int FW = 4;
    localparam int OS = 16;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          enable_i;
    logic          restart_i;
    logic [IW-1:0] div_int_i;
    logic [FW-1:0] div_frac_i;
    logic          sample_en_o;
    logic          bit_en_o;
    logic          cfg_err_o;

    int checks = 0;
    int errors = 0;

    frac_baud_generator #(
        .DIV_INT_WIDTH  (IW),
        .DIV_FRAC_WIDTH (FW),
        .OVERSAMPLE     (OS)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .enable_i    (enable_i),
        .restart_i   (restart_i),
        .div_int_i   (div_int_i),
        .div_frac_i  (div_frac_i),
        .sample_en_o (sample_en_o),
        .bit_en_o    (bit_en_o),
        .cfg_err_o   (cfg_err_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_restart();
        restart_i = 1'b1;
        step();
        restart_i = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        rst_i = 1'b1; enable_i = 1'b1; restart_i = 1'b0;
        div_int_i = 16'd4; div_frac_i = 4'd0;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (sample_en_o !== 1'b0 || bit_en_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_ticks cyc=%0d got sample=%b bit=%b want 0/0", i, sample_en_o, bit_en_o);
            end
        end
        checks++;
        if (cfg_err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_cfg_err got %b want 0", cfg_err_o);
        end
        div_int_i = 16'd1;
        #1;
        checks++;
        if (cfg_err_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_cfg_err_div1 got %b want 1", cfg_err_o);
        end
        div_int_i = 16'd4;
        step();
        rst_i = 1'b0;
        // first post-reset edge sees a divisor change (restart), then a full period
        n = 0;
        while (n < 20) begin
            step();
            n++;
            if (sample_en_o === 1'b1) break;
        end
        checks++;
        if (n !== 5) begin
            errors++;
            $display("FAIL reset_release_latency got %0d want 5", n);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        div_int_i = 16'd4; div_frac_i = 4'd0;
        step();
        do_restart();
        checks++;
        if (sample_en_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_restart_tick got %b want 0", sample_en_o);
        end
        for (int k = 1; k <= 130; k++) begin
            step();
            checks++;
            if (sample_en_o !== (k % 4 == 0) || bit_en_o !== (k % 64 == 0)) begin
                errors++;
                $display("FAIL basic_div4 k=%0d got sample=%b bit=%b want %b/%b",
                         k, sample_en_o, bit_en_o, (k % 4 == 0), (k % 64 == 0));
            end
        end
        $display("test_basic done");
    endtask

    task automatic test_fraction();
        int t[$];
        int k;
`ifdef BAUD_GEN_FRAC_DIV_EN
        div_int_i = 16'd4; div_frac_i = 4'd8;
        step();
        do_restart();
        k = 0;
        while (t.size() < 33 && k < 400) begin
            step();
            k++;
            if (sample_en_o === 1'b1) t.push_back(k);
        end
        checks++;
        if (t.size() !== 33) begin
            errors++;
            $display("FAIL frac_tick_count got %0d want 33", t.size());
        end else begin
            checks++;
            if (t[0] !== 4) begin
                errors++;
                $display("FAIL frac_first_period got %0d want 4", t[0]);
            end
            for (int i = 1; i < 33; i++) begin
                checks++;
                if (t[i] - t[i-1] !== ((i % 2 == 1) ? 4 : 5)) begin
                    errors++;
                    $display("FAIL frac_period i=%0d got %0d want %0d", i, t[i] - t[i-1], (i % 2 == 1) ? 4 : 5);
                end
            end
            checks++;
            if (t[32] - t[0] !== 144) begin
                errors++;
                $display("FAIL frac_32_ticks got %0d want 144", t[32] - t[0]);
            end
        end
`else
        div_int_i = 16'd27; div_frac_i = 4'd2;
        step();
        do_restart();
        k = 0;
        while (t.size() < 5 && k < 400) begin
            step();
            k++;
            if (sample_en_o === 1'b1) t.push_back(k);
            // the fraction input must be ignored entirely, including for restarts
            if (t.size() == 2 && k == t[1] + 5) div_frac_i = 4'd9;
        end
        checks++;
        if (t.size() !== 5) begin
            errors++;
            $display("FAIL int_tick_count got %0d want 5", t.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (((i == 0) ? t[0] : t[i] - t[i-1]) !== 27) begin
                    errors++;
                    $display("FAIL int_period i=%0d got %0d want 27", i, (i == 0) ? t[0] : t[i] - t[i-1]);
                end
            end
        end
        div_frac_i = 4'd0;
`endif
        $display("test_fraction done");
    endtask

    task automatic test_div_change();
        div_int_i = 16'd10; div_frac_i = 4'd0;
        step();
        do_restart();
        for (int k = 1; k <= 37; k++) begin
            step();
            checks++;
            if (sample_en_o !== (k % 10 == 0)) begin
                errors++;
                $display("FAIL div10 k=%0d got %b want %b", k, sample_en_o, (k % 10 == 0));
            end
        end
        div_int_i = 16'd6;
        step();
        checks++;
        if (sample_en_o !== 1'b0 || bit_en_o !== 1'b0) begin
            errors++;
            $display("FAIL div_change_tick got sample=%b bit=%b want 0/0", sample_en_o, bit_en_o);
        end
        for (int k = 1; k <= 100; k++) begin
            step();
            checks++;
            if (sample_en_o !== (k % 6 == 0) || bit_en_o !== (k == 96)) begin
                errors++;
                $display("FAIL div6 k=%0d got sample=%b bit=%b want %b/%b",
                         k, sample_en_o, bit_en_o, (k % 6 == 0), (k == 96));
            end
        end
        $display("test_div_change done");
    endtask

    task automatic test_cfg_err();
        div_int_i = 16'd1;
        #1;
        checks++;
        if (cfg_err_o !== 1'b1) begin
            errors++;
            $display("FAIL cfg_err_div1 got %b want 1", cfg_err_o);
        end
        for (int k = 0; k < 10; k++) begin
            step();
            checks++;
            if (sample_en_o !== 1'b0 || bit_en_o !== 1'b0 || cfg_err_o !== 1'b1) begin
                errors++;
                $display("FAIL cfg_err_hold k=%0d got sample=%b bit=%b err=%b want 0/0/1",
                         k, sample_en_o, bit_en_o, cfg_err_o);
            end
        end
        div_int_i = 16'd2;
        #1;
        checks++;
        if (cfg_err_o !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err_div2 got %b want 0", cfg_err_o);
        end
        step();
        for (int k = 1; k <= 20; k++) begin
            step();
            checks++;
            if (sample_en_o !== (k % 2 == 0)) begin
                errors++;
                $display("FAIL div2 k=%0d got %b want %b", k, sample_en_o, (k % 2 == 0));
            end
        end
        $display("test_cfg_err done");
    endtask

    task automatic test_enable_reset();
        div_int_i = 16'd8;
        step();
        do_restart();
        for (int k = 0; k < 3; k++) step();
        enable_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (sample_en_o !== 1'b0 || bit_en_o !== 1'b0) begin
                errors++;
                $display("FAIL enable_low k=%0d got sample=%b bit=%b want 0/0", k, sample_en_o, bit_en_o);
            end
        end
        enable_i = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            step();
            checks++;
            if (sample_en_o !== (k % 8 == 0)) begin
                errors++;
                $display("FAIL enable_resume k=%0d got %b want %b", k, sample_en_o, (k % 8 == 0));
            end
        end
        do_restart();
        for (int k = 0; k < 3; k++) step();
        rst_i = 1'b1;
        step();
        checks++;
        if (sample_en_o !== 1'b0 || bit_en_o !== 1'b0) begin
            errors++;
            $display("FAIL midreset got sample=%b bit=%b want 0/0", sample_en_o, bit_en_o);
        end
        rst_i = 1'b0;
        step();
        checks++;
        if (sample_en_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_tick got %b want 0", sample_en_o);
        end
        for (int k = 1; k <= 17; k++) begin
            step();
            checks++;
            if (sample_en_o !== (k % 8 == 0)) begin
                errors++;
                $display("FAIL reset_resume k=%0d got %b want %b", k, sample_en_o, (k % 8 == 0));
            end
        end
        $display("test_enable_reset done");
    endtask

    task automatic test_back_to_back();
        div_int_i = 16'd4;
        step();
        do_restart();
        for (int k = 0; k < 3; k++) step();
        restart_i = 1'b1;
        step();
        restart_i = 1'b0;
        checks++;
        if (sample_en_o !== 1'b0) begin
            errors++;
            $display("FAIL restart_vs_terminal got %b want 0", sample_en_o);
        end
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++;
            if (sample_en_o !== (k % 4 == 0)) begin
                errors++;
                $display("FAIL after_restart k=%0d got %b want %b", k, sample_en_o, (k % 4 == 0));
            end
        end
        $display("test_back_to_back done");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_fraction();
        test_div_change();
        test_cfg_err();
        test_enable_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frac_baud_generator.md
FRAC_BAUD_GENERATOR -- requirements
Module: frac_baud_generator

Interface
REQ-001 SHALL have parameter DIV_INT_WIDTH, default 16, the width of the integer divisor.
REQ-002 SHALL have parameter DIV_FRAC_WIDTH, default 4, the width of the fractional divisor (units of 1/2^DIV_FRAC_WIDTH cycle).
REQ-003 SHALL have parameter OVERSAMPLE, default 16, the number of sample ticks per bit tick; legal values are powers of two from 4 to 64.
REQ-004 SHALL have port clk_i, input, 1 bit, single clock.
REQ-005 SHALL have port rst_i, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port enable_i, input, 1 bit, generator run enable.
REQ-007 SHALL have port restart_i, input, 1 bit, single-cycle phase-restart request.
REQ-008 SHALL have port div_int_i, input, DIV_INT_WIDTH bits, integer sample period in clk_i cycles.
REQ-009 SHALL have port div_frac_i, input, DIV_FRAC_WIDTH bits, fractional sample period.
REQ-010 SHALL have port sample_en_o, output, 1 bit, one-cycle sample-tick pulse.
REQ-011 SHALL have port bit_en_o, output, 1 bit, one-cycle bit-tick pulse.
REQ-012 SHALL have port cfg_err_o, output, 1 bit, illegal divisor flag.

Function
REQ-013 SHALL register {div_int_i, div_frac_i} every cycle; a difference between the inputs and the registered copy SHALL be treated as a restart, as SHALL restart_i=1.
REQ-014 On restart: period counter, fraction accumulator, carry flag and oversample counter SHALL clear, and no tick SHALL be issued that cycle. The first sample_en_o SHALL follow a full new period.
REQ-015 Terminal count SHALL be: period counter == div_int_i-1+carry. At terminal count the counter SHALL clear and sample_en_o SHALL be 1 in the next cycle (registered; one-cycle latency).
REQ-016 At terminal count: accumulator <= (accumulator+div_frac_i) mod 2^DIV_FRAC_WIDTH, and carry <= the carry-out of that addition. The average period SHALL be div_int_i+div_frac_i/2^DIV_FRAC_WIDTH cycles with no drift.
REQ-017 The oversample counter SHALL increment on each sample tick and wrap at OVERSAMPLE-1. bit_en_o SHALL pulse in the same cycle as the sample_en_o that wraps it.
REQ-018 With enable_i=0, all counters SHALL be held cleared and both tick outputs SHALL be 0. After enable_i rises, the first sample tick SHALL occur a full period later.
REQ-019 With div_int_i<2, cfg_err_o SHALL be 1 (combinational from inputs) and the block SHALL behave as with enable_i=0.
REQ-020 Simultaneous restart and terminal count: restart SHALL win and no tick SHALL be issued.

Reset
REQ-021 While rst_i=1: sample_en_o=0, bit_en_o=0, all counters, accumulator and carry SHALL be 0, and the registered divisor SHALL be 0. cfg_err_o SHALL follow REQ-019 only.
REQ-022 Reset asserted mid-period SHALL take effect on the next clk_i edge. Ticking SHALL resume a full period after rst_i is released.

Configuration
REQ-023 Macro BAUD_GEN_FRAC_DIV_EN SHALL compile in the fractional accumulator.
REQ-024 Without BAUD_GEN_FRAC_DIV_EN: div_frac_i SHALL be ignored, the accumulator and carry logic SHALL be absent, carry SHALL be treated as 0, and the period SHALL be exactly div_int_i.

Structure
REQ-025 Package baud_gen_pkg SHALL hold the default widths, OVERSAMPLE and the 50 MHz divisor constants: 9600={325,8}, 19200={162,12}, 115200={27,2}, 256000={12,3}.
REQ-026 A sub-module frac_accumulator SHALL hold the accumulator and carry logic, instantiated only under BAUD_GEN_FRAC_DIV_EN.

Verification
REQ-027 Scenario: div_int=4, frac=0, enable=1 -> sample_en_o every 4 cycles; bit_en_o every 64 cycles.
REQ-028 Scenario: div_int=4, frac=8 (with the macro) -> sample periods alternate 4,5,4,5; 32 ticks take exactly 144 cycles.
REQ-029 Scenario: change div_int from 10 to 6 at count 7 -> no tick that cycle; the next tick arrives 6 cycles later, and the oversample counter restarts at 0.
REQ-030 Scenario: div_int=1 -> cfg_err_o=1 and no ticks; set div_int=2 -> cfg_err_o=0 and ticks every 2 cycles.
REQ-031 Scenario: enable_i dropped for 3 cycles mid-period, and rst_i pulsed at count 3 of 8 -> outputs 0, then the first tick arrives a full period after release.
REQ-032 Scenario: macro undefined, div_int=27, frac=2 -> period is exactly 27 cycles every time.
